// File: rtl/wam_game_ctrl.sv
// Whack-a-mole game engine: button sync/edge detect, LFSR mole draw, dwell timing, scoring,
// IDLE/PLAY/PAUSED/OVER sequencing. Optional button debounce with WAM_DEBOUNCE_EN.
module wam_game_ctrl #(
  parameter int         TICK_DIV        = 25_000_000,
  parameter int         MOLE_TICKS      = 2,
  parameter logic [7:0] LFSR_SEED       = 8'hA5,
  parameter int         DEBOUNCE_CYCLES = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [4:0] whack_btn,
  input  logic       timer_done,
  output logic [2:0] oval_select,
  output logic [3:0] score,
  output logic       enable,
  output logic       pause,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(MOLE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(MOLE_TICKS);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_PAUSED, ST_OVER} state_t;

  function automatic logic [2:0] pick_mole(input logic [7:0] rnd, input logic [2:0] prev);
    logic [2:0] cand;
    cand = 3'(rnd % 8'd5) + 3'd1;
    if (cand == prev) begin
      cand = (cand == 3'd5) ? 3'd1 : cand + 3'd1;
    end
    return cand;
  endfunction

  function automatic logic [4:0] mole_mask(input logic [2:0] mole);
    case (mole)
      3'd1:    return 5'b00001;
      3'd2:    return 5'b00010;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b01000;
      3'd5:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  logic [6:0]    btn_s, sync1_r, sync2_r, level_s, level_d_r, edge_r;
  logic          start_e_s, pause_e_s;
  logic [4:0]    whack_e_s;
  logic [7:0]    lfsr_r;
  logic [2:0]    last_mole_r, draw_s;
  logic          hit_flag_r, tick_s, expire_s, hit_s;
  logic [TW-1:0] tick_cnt_r;
  logic [DW-1:0] dwell_r;
  state_t        state_r;

  assign btn_s = {whack_btn, pause_btn, start_btn};

  // two-flop synchroniser for all raw buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 7'd0;
      sync2_r <= 7'd0;
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
    end
  end

`ifdef WAM_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [6:0]    deb_r;
  logic [CW-1:0] deb_cnt_r [7];

  // level follows the synchronised input only after it has differed for the full window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_r <= 7'd0;
      for (int i = 0; i < 7; i++) deb_cnt_r[i] <= CW'(0);
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= CW'(0);
        end else if (deb_cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_r[i]     <= sync2_r[i];
          deb_cnt_r[i] <= CW'(0);
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + CW'(1);
        end
      end
    end
  end
  assign level_s = deb_r;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (DEBOUNCE_CYCLES > 0);
  assign level_s = sync2_r;
`endif

  // registered rising-edge strobes and free-running LFSR (taps 8,6,5,4)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d_r <= 7'd0;
      edge_r    <= 7'd0;
      lfsr_r    <= LFSR_SEED;
    end else begin
      level_d_r <= level_s;
      edge_r    <= level_s & ~level_d_r;
      lfsr_r    <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  assign start_e_s = edge_r[0];
  assign pause_e_s = edge_r[1];
  assign whack_e_s = edge_r[6:2];
  assign draw_s    = pick_mole(lfsr_r, last_mole_r);
  assign tick_s    = (tick_cnt_r == TICK_LAST);
  // dwell of 0 only occurs when the final tick landed on the pause cycle; redraw on resume
  assign expire_s  = (dwell_r == DW'(0)) || (tick_s && (dwell_r == DW'(1)));
  assign hit_s     = (|(whack_e_s & mole_mask(oval_select))) && !hit_flag_r;

  // game FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      oval_select <= 3'd0;
      score       <= 4'd0;
      enable      <= 1'b0;
      pause       <= 1'b0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      last_mole_r <= 3'd0;
      hit_flag_r  <= 1'b0;
      tick_cnt_r  <= TW'(0);
      dwell_r     <= DW'(0);
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state_r)
        ST_IDLE, ST_OVER: begin
          pause <= 1'b0;
          if (start_e_s) begin
            state_r     <= ST_PLAY;
            enable      <= 1'b1;
            score       <= 4'd0;
            oval_select <= draw_s;
            last_mole_r <= draw_s;
            hit_flag_r  <= 1'b0;
            tick_cnt_r  <= TW'(0);
            dwell_r     <= DWELL_LOAD;
          end else begin
            enable      <= 1'b0;
            oval_select <= 3'd0;
          end
        end
        ST_PLAY: begin
          if (timer_done) begin
            state_r     <= ST_OVER;
            enable      <= 1'b0;
            pause       <= 1'b0;
            oval_select <= 3'd0;
          end else begin
            tick_cnt_r <= tick_s ? TW'(0) : tick_cnt_r + TW'(1);
            if (tick_s && (dwell_r != DW'(0))) begin
              dwell_r <= dwell_r - DW'(1);
            end
            if (pause_e_s) begin
              state_r <= ST_PAUSED;
              pause   <= 1'b1;
            end else begin
              if (hit_s) begin
                score       <= (score == 4'd15) ? 4'd15 : score + 4'd1;
                hit_pulse   <= 1'b1;
                oval_select <= 3'd0;
                hit_flag_r  <= 1'b1;
              end
              if (expire_s) begin
                miss_pulse  <= !hit_flag_r && !hit_s;
                oval_select <= draw_s;
                last_mole_r <= draw_s;
                hit_flag_r  <= 1'b0;
                tick_cnt_r  <= TW'(0);
                dwell_r     <= DWELL_LOAD;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (timer_done) begin
            state_r     <= ST_OVER;
            enable      <= 1'b0;
            pause       <= 1'b0;
            oval_select <= 3'd0;
          end else if (pause_e_s) begin
            state_r <= ST_PLAY;
            pause   <= 1'b0;
          end else begin
            pause <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          enable      <= 1'b0;
          pause       <= 1'b0;
          oval_select <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/wam_game_ctrl.md
# wam_game_ctrl

Game-control engine for the whack-a-mole design. It produces the mole position, score, run and pause status consumed by the VGA display path, and consumes that path's timer-expiry signal. Player buttons are synchronised and edge-detected. A pseudo-random mole is raised for a fixed dwell time. Hits are scored, and a four-state FSM sequences idle, play, pause and game-over.

## Interface
- TICK_DIV, 25_000_000: clk cycles per game tick (1 s at 25 MHz).
- MOLE_TICKS, 2: ticks a mole stays up before a new one is drawn (≥1).
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.
- DEBOUNCE_CYCLES, 250_000: stability window; used only with WAM_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start_btn  in  1  raw start button, asynchronous.
- pause_btn  in  1  raw pause toggle button, asynchronous.
- whack_btn  in  5  raw hit buttons; bit k targets oval k+1.
- timer_done  in  1  level from the game timer; high means time expired.
- oval_select  out  3  active mole, 1..5; 0 = none.
- score  out  4  hit count, saturating at 15.
- enable  out  1  game running; high in PLAY and PAUSED.
- pause  out  1  high in PAUSED.
- hit_pulse  out  1  one-cycle strobe on a scored hit.
- miss_pulse  out  1  one-cycle strobe when a mole expires unhit.

## Operation
- **Inputs:** each raw button passes through a 2-flop synchroniser, then a rising-edge detector. Downstream logic sees only 1-cycle edge strobes: start_e, pause_e, whack_e[4:0].
- **LFSR:** 8-bit Fibonacci LFSR, taps 8,6,5,4. It shifts every clk in every state.
- **Mole draw:** cand = (lfsr % 5) + 1. If cand equals the previous nonzero mole, use cand+1 instead, wrapping 5→1.
- **Tick counter:** counts 0..TICK_DIV-1 in PLAY only. It emits a tick on the wrap.
- **Dwell counter:** loads MOLE_TICKS at each draw and decrements on each tick. At 0 it triggers a redraw.
- **Hit flag:** set when the current mole has been scored.

FSM states, all outputs registered:
- **IDLE** (reset state): enable=0, oval_select=0.
  - start_e → PLAY. On entry, score is cleared, a mole is drawn, the counters are loaded and the hit flag is cleared.
- **PLAY**: enable=1. Conditions are evaluated in priority order:
  1. timer_done → OVER.
  2. pause_e → PAUSED.
  3. whack_e bit matching oval_select-1 while oval_select≠0 and hit flag clear: score+1 (held at 15 when already 15), hit_pulse=1, oval_select←0, hit flag set.
  4. Dwell expiry: miss_pulse=1 if hit flag clear, a new mole is drawn, dwell is reloaded and the hit flag is cleared.
  - Rules 3 and 4 in the same cycle: the hit is scored first and the redraw still happens; no miss_pulse.
  - Non-matching whack edges are ignored, as are all whacks while oval_select=0.
- **PAUSED**: enable=1, pause=1.
  - Tick and dwell counters are frozen, oval_select is held, and whack_e is ignored.
  - timer_done → OVER (priority). pause_e → PLAY, resuming the counters where they stopped.
- **OVER**: enable=0, pause=0, oval_select=0. score is held for display.
  - start_e → PLAY, with the same entry actions as from IDLE.
- start_e is ignored in PLAY and PAUSED.
- **Reset** (any time, mid-game included): the FSM goes to IDLE. All outputs, counters and synchronisers are cleared to 0; lfsr=LFSR_SEED.

## Timing
- **Reset values:** oval_select=0, score=0, enable=0, pause=0, hit_pulse=0, miss_pulse=0.
- **Button latency:** a button rising before clk edge N is visible on the outputs after edge N+3. That is two synchroniser edges, one edge-detect edge and one registered-update edge.
- **timer_done latency:** sampled directly, since it comes from the clk domain. The FSM is in OVER one cycle after timer_done is first seen high in PLAY or PAUSED.
- **Dwell period:** exactly MOLE_TICKS×TICK_DIV clk cycles of PLAY, not counting PAUSED cycles.
- **Strobes:** hit_pulse and miss_pulse are exactly one cycle wide and never both high.

## Configuration
- WAM_DEBOUNCE_EN defined: each synchronised button feeds a per-button counter. The debounced level changes only after the input has held a new value for DEBOUNCE_CYCLES consecutive cycles. This adds DEBOUNCE_CYCLES cycles to the button latency.
- Undefined: there is no debounce stage, and the edge detector is driven directly from the synchroniser.

## Test plan
All scenarios use TICK_DIV=4, MOLE_TICKS=3, WAM_DEBOUNCE_EN undefined.

- **Reset/start:** release rst, pulse start_btn. Expect enable=1, score=0 and oval_select in 1..5 three edges later; oval_select=0 before that.
- **Hit:** whack the bit matching oval_select. Expect score 0→1, hit_pulse for 1 cycle, oval_select=0. A second whack before the redraw leaves score=1.
- **Miss and redraw:** no whack. Expect miss_pulse and a new oval_select ≠ the previous one exactly 12 cycles after the draw; check 50 consecutive draws for no repeats.
- **Pause:** pulse pause_btn mid-dwell and hold PAUSED 40 cycles. Expect pause=1, oval_select unchanged, whacks ignored. After the second pause_btn, the redraw occurs after the remaining dwell cycles only.
- **Saturation/game over:** score 16 hits. Expect score=15 with a hit_pulse on the 16th. Raise timer_done: expect OVER next cycle with enable=0, oval_select=0, score=15. Then start_btn gives score=0.
- **Reset mid-game:** assert rst in PAUSED with score=7. Expect all outputs 0 immediately and IDLE after release.
